fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter PC_W, default 8, meaning the word-address width of the PC and instruction memory address.
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning the instruction buffer entry count, fixed at 2.
REQ-003 The module SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-004 The design SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 imem_req  output  1  instruction memory read request, registered.
REQ-008 imem_addr  output  PC_W  word address of the request, registered.
REQ-009 imem_ack  input  1  memory accepts the request and returns imem_rdata in the same cycle.
REQ-010 imem_rdata  input  16  instruction word, valid only when imem_ack=1.
REQ-011 inst  output  16  instruction presented to the control unit.
REQ-012 inst_pc  output  PC_W  address of the instruction on inst.
REQ-013 inst_valid  output  1  inst and inst_pc hold a valid buffered instruction.
REQ-014 inst_ready  input  1  downstream consumes inst this cycle.
REQ-015 redirect  input  1  flush buffer and restart fetch at redirect_pc.
REQ-016 redirect_pc  input  PC_W  new fetch address.

Function
REQ-017 The FSM SHALL have states IDLE (no request outstanding) and WAIT (imem_req=1, awaiting imem_ack).
REQ-018 Entry condition: IDLE->WAIT when occupancy < DEPTH; imem_addr<=pc and pc<=pc+1 on the same edge.
REQ-019 imem_req and imem_addr SHALL stay stable in WAIT until the imem_ack cycle.
REQ-020 In the imem_ack cycle, imem_rdata and the request address SHALL be pushed into the buffer, unless drop=1 or redirect=1.
REQ-021 On ack, the FSM SHALL stay in WAIT with the next address if (occupancy after push/pop) < DEPTH; otherwise it SHALL go to IDLE.
REQ-022 Sustained throughput SHALL be one instruction per cycle when imem_ack and inst_ready are held high.
REQ-023 PC arithmetic SHALL be modulo 2^PC_W: pc=8'hFF increments to 8'h00.
REQ-024 inst_valid SHALL equal buffer-not-empty; a pop occurs on inst_valid & inst_ready.
REQ-025 inst_ready while inst_valid=0 SHALL have no effect.
REQ-026 Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.
REQ-027 A request SHALL be issued only when a free entry is reserved, so a push never meets a full buffer.
REQ-028 When inst_valid=0, inst SHALL be NOP_INST (16'hF000, decoded as NOP) and inst_pc SHALL be 0.
REQ-029 redirect SHALL override all other events in its cycle: the buffer is emptied, any pop ignored, and pc<=redirect_pc.
REQ-030 If redirect is asserted in WAIT without ack, the drop flag SHALL set; the outstanding response is discarded on its ack, then fetch resumes at redirect_pc.
REQ-031 If redirect coincides with imem_ack, that response SHALL be discarded and drop SHALL stay 0.
REQ-032 inst_valid SHALL be 0 in the cycle after a redirect.
REQ-033 Latency: first imem_req=1 on the first cycle after rst deasserts; an immediate ack yields inst_valid=1 on the next cycle.

Reset
REQ-034 Reset SHALL set pc=RESET_PC, state=IDLE, buffer empty, drop=0, imem_req=0, imem_addr=0, inst_valid=0, inst=NOP_INST, inst_pc=0.
REQ-035 Reset asserted mid-WAIT SHALL abandon the request; an ack during reset SHALL be ignored.

Structure
REQ-036 Package cpu_pkg SHALL hold the opcode constants (ADD=4'h0, ADDI=4'h1, LD=4'h2, SW=4'h3), NOP_INST, INST_W=16 and the fetch FSM state encoding.
REQ-037 The 2-entry {pc, inst} buffer SHALL be a sub-module inst_fifo with push, pop, flush, full, empty and count.

Verification
REQ-038 Reset release, ack tied 1, ready=1 -> imem_addr 0,1,2,... on consecutive cycles; inst_pc trails by one cycle; no bubbles.
REQ-039 ready=0 with ack=1 -> two instructions buffered (pc 0,1), imem_req drops to 0; raising ready -> pc 0 then 1 delivered and fetch resumes at 2.
REQ-040 imem_req held 3 cycles before ack with rdata=16'h1234 at addr 5 -> imem_addr stable at 5 throughout; inst=16'h1234, inst_pc=5 next cycle.
REQ-041 redirect to 8'h40 while a request to 8'h07 is outstanding -> the late 8'h07 data is never presented; next valid inst_pc=8'h40.
REQ-042 redirect coincident with ack, and separately pc=8'hFF -> redirect data discarded; the wrap case fetches 8'hFF then 8'h00.
REQ-043 rst pulsed mid-WAIT with ack -> all outputs at reset values next cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, opcodes, the NOP word and the fetch FSM state encoding.
package cpu_pkg;

    localparam int INST_W = 16;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;

    // Opcode 4'hF is outside the ISA and decodes as NOP.
    localparam logic [INST_W-1:0] NOP_INST = 16'hF000;

    localparam logic [0:0] FS_IDLE = 1'b0;
    localparam logic [0:0] FS_WAIT = 1'b1;

endpackage

// File: rtl/inst_fifo.sv
// Small {pc, inst} FIFO; registered head, writes land one cycle after push.
// Push into a full FIFO and pop from an empty one are the caller's job to prevent; flush wins over both.
module inst_fifo
    import cpu_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic [PC_W-1:0]           push_pc_i,
    input  logic [INST_W-1:0]         push_inst_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    output logic [PC_W-1:0]           head_pc_o,
    output logic [INST_W-1:0]         head_inst_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            pc_mem[wr_ptr_q]   <= push_pc_i;
            inst_mem[wr_ptr_q] <= push_inst_i;
        end
    end

    assign head_pc_o   = pc_mem[rd_ptr_q];
    assign head_inst_o = inst_mem[rd_ptr_q];
    assign full_o      = (count_q == DEPTH_C);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer, 1 inst/cycle when ack and ready stay high.
// Requests are issued only with a free buffer slot reserved; redirect flushes and drops any in-flight response.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [0:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic              drop_q, drop_d;

    logic              fifo_push, fifo_pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, count_after;
    logic [PC_W-1:0]   head_pc;
    logic [INST_W-1:0] head_inst;
    logic              ack_c;

    assign ack_c     = (state_q == FS_WAIT) && imem_ack;
    assign fifo_pop  = !fifo_empty && inst_ready && !redirect;
    assign fifo_push = ack_c && !drop_q && !redirect;

    always_comb begin
        count_after = fifo_count;
        case ({fifo_push, fifo_pop})
            2'b10:   count_after = fifo_count + 1'b1;
            2'b01:   count_after = fifo_count - 1'b1;
            default: count_after = fifo_count;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        if (redirect) begin
            pc_d = redirect_pc;
            // Without an ack the old request must stay on the bus; remember to discard its data.
            if (state_q == FS_WAIT && !imem_ack) begin
                drop_d = 1'b1;
            end else begin
                state_d = FS_IDLE;
                drop_d  = 1'b0;
            end
        end else if (state_q == FS_IDLE) begin
            if (!fifo_full) begin
                state_d = FS_WAIT;
                addr_d  = pc_q;
                pc_d    = pc_q + 1'b1;
            end
        end else if (imem_ack) begin
            drop_d = 1'b0;
            if (count_after < DEPTH_C) begin
                addr_d = pc_q;
                pc_d   = pc_q + 1'b1;
            end else begin
                state_d = FS_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    inst_fifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_pc_i   (addr_q),
        .push_inst_i (imem_rdata),
        .pop_i       (fifo_pop),
        .flush_i     (redirect),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign imem_req   = (state_q == FS_WAIT);
    assign imem_addr  = addr_q;
    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? NOP_INST : head_inst;
    assign inst_pc    = fifo_empty ? '0 : head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model compared every cycle, plus directed literal checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;

    logic        ovr_en  = 1'b0;
    logic [15:0] ovr_dat = 16'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [7:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    assign imem_rdata = ovr_en ? ovr_dat : memf(imem_addr);

    fetch_unit #(
        .PC_W     (8),
        .DEPTH    (2),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one outstanding request (m_pend/m_addr/m_drop), a queue of delivered words.
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ins;
    } ent_t;

    ent_t       q[$];
    bit         m_pend = 0;
    bit         m_drop = 0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_pc   = 8'h00;
    bit         started = 0;

    always @(posedge clk) begin
        int          occ0;
        logic [15:0] rd;
        ent_t        e;
        started = 1;
        if (rst) begin
            q.delete();
            m_pend = 0;
            m_drop = 0;
            m_addr = 8'h00;
            m_pc   = 8'h00;
        end else begin
            occ0 = q.size();
            rd   = ovr_en ? ovr_dat : memf(m_addr);
            if (redirect) begin
                q.delete();
                if (m_pend && !imem_ack) begin
                    m_drop = 1;
                end else begin
                    m_pend = 0;
                    m_drop = 0;
                end
                m_pc = redirect_pc;
            end else begin
                if (q.size() > 0 && inst_ready) void'(q.pop_front());
                if (m_pend) begin
                    if (imem_ack) begin
                        if (!m_drop) begin
                            e.pc  = m_addr;
                            e.ins = rd;
                            q.push_back(e);
                        end
                        m_drop = 0;
                        if (q.size() < 2) begin
                            m_addr = m_pc;
                            m_pc   = m_pc + 8'd1;
                        end else begin
                            m_pend = 0;
                        end
                    end
                end else if (occ0 < 2) begin
                    m_pend = 1;
                    m_addr = m_pc;
                    m_pc   = m_pc + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_req",   imem_req,   m_pend);
            chk("model_addr",  imem_addr,  m_addr);
            chk("model_valid", inst_valid, q.size() > 0);
            chk("model_inst",  inst,       (q.size() > 0) ? q[0].ins : 16'hF000);
            chk("model_pc",    inst_pc,    (q.size() > 0) ? q[0].pc : 8'h00);
        end
    end

    task automatic cyc(input bit r, input bit a, input bit rdy, input bit rdr, input logic [7:0] rp);
        rst         = r;
        imem_ack    = a;
        inst_ready  = rdy;
        redirect    = rdr;
        redirect_pc = rp;
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc(1, 1, 1, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        chk("rst_req",   imem_req,   0);
        chk("rst_addr",  imem_addr,  8'h00);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst",  inst,       16'hF000);
        chk("rst_pc",    inst_pc,    8'h00);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;

        // Streaming after reset: addresses 0,1,2,... with inst_pc one cycle behind.
        do_reset();
        cyc(0, 1, 1, 0, 8'h00);
        chk("first_req",  imem_req,  1);
        chk("first_addr", imem_addr, 8'h00);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 1, 0, 8'h00);
            chk("stream_valid", inst_valid, 1);
            chk("stream_pc",    inst_pc,    k);
            chk("stream_inst",  inst,       memf(8'(k)));
            chk("stream_addr",  imem_addr,  k + 1);
        end

        // Backpressure fills both entries, then drains in order and resumes at 2.
        do_reset();
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("bp_req_off", imem_req, 0);
        chk("bp_head0",   inst_pc,  8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        chk("bp_hold",    imem_req, 0);
        cyc(0, 1, 1, 0, 8'h00);
        chk("bp_head1",   inst_pc,  8'h01);
        cyc(0, 1, 1, 0, 8'h00);
        chk("bp_empty",   inst_valid, 0);
        chk("bp_resume",  imem_addr,  8'h02);
        cyc(0, 1, 1, 0, 8'h00);
        chk("bp_pc2",     inst_pc,  8'h02);

        // Slow memory at address 5.
        do_reset();
        cyc(0, 0, 1, 1, 8'h05);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 0, 8'h00);
            chk("slow_req",  imem_req,  1);
            chk("slow_addr", imem_addr, 8'h05);
        end
        ovr_en = 1'b1; ovr_dat = 16'h1234;
        cyc(0, 1, 1, 0, 8'h00);
        ovr_en = 1'b0;
        chk("slow_inst", inst,    16'h1234);
        chk("slow_pc",   inst_pc, 8'h05);

        // Redirect to 0x40 while the request to 0x07 is outstanding.
        do_reset();
        cyc(0, 0, 1, 1, 8'h07);
        cyc(0, 0, 1, 0, 8'h00);
        chk("drop_addr7", imem_addr, 8'h07);
        cyc(0, 0, 1, 1, 8'h40);
        chk("drop_hold",  imem_addr, 8'h07);
        chk("drop_inv",   inst_valid, 0);
        cyc(0, 1, 1, 0, 8'h00);
        chk("drop_skip",  inst_valid, 0);
        chk("drop_addr40", imem_addr, 8'h40);
        cyc(0, 1, 1, 0, 8'h00);
        chk("drop_pc40",  inst_pc, 8'h40);

        // Redirect coinciding with an ack, then a redirect that wraps the PC.
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 1, 1, 1, 8'h20);
        chk("rdack_valid", inst_valid, 0);
        chk("rdack_req",   imem_req,   0);
        cyc(0, 1, 1, 0, 8'h00);
        chk("rdack_addr",  imem_addr, 8'h20);
        cyc(0, 1, 1, 0, 8'h00);
        chk("rdack_pc",    inst_pc, 8'h20);
        cyc(0, 1, 1, 1, 8'hFF);
        cyc(0, 1, 1, 0, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        chk("wrap_ff", inst_pc, 8'hFF);
        cyc(0, 1, 1, 0, 8'h00);
        chk("wrap_00", inst_pc, 8'h00);

        // Reset pulse during an acked request.
        cyc(1, 1, 1, 0, 8'h00);
        chk("midrst_req",   imem_req,   0);
        chk("midrst_valid", inst_valid, 0);
        chk("midrst_inst",  inst,       16'hF000);
        chk("midrst_addr",  imem_addr,  8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        chk("midrst_restart", imem_addr, 8'h00);
        cyc(0, 1, 1, 0, 8'h00);
        chk("midrst_pc0", inst_pc, 8'h00);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            cyc($urandom_range(99) == 0,
                $urandom_range(9) < 7,
                $urandom_range(9) < 7,
                $urandom_range(19) == 0,
                8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
